// File: rtl/dmem_arbiter.sv
// Purpose : two-master (CPU / AUX) round-robin arbiter for the single data-memory port,
//           bounded burst tenure while the other master is waiting.
// Latency : zero - grant, memory mux and read data are combinational in the request cycle.
// Backpr. : the losing master sees Gnt=0 (CPU also sees CpuStall) and must hold its request.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   Cpu{Req,Write,Addr,WData} CPU request; CpuGnt / CpuStall / CpuRData responses
//   Aux{Req,Write,Addr,WData} AUX request; AuxGnt / AuxRData responses
//   Mem{Addr,Read,Write,WData} memory strobes from the granted master; MemRData read data in
//   Owner                     current tenure holder (0=IDLE, 1=CPU, 2=AUX)
//   CpuAccCnt, AuxAccCnt      wrapping counts of granted accesses per master
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CpuReq,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuGnt,
    output logic              CpuStall,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              AuxReq,
    input  logic              AuxWrite,
    input  logic [ADDR_W-1:0] AuxAddr,
    input  logic [DATA_W-1:0] AuxWData,
    output logic              AuxGnt,
    output logic [DATA_W-1:0] AuxRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic [1:0]        Owner,
    output logic [CNT_W-1:0]  CpuAccCnt,
    output logic [CNT_W-1:0]  AuxAccCnt
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    owner_t           r_owner;
    logic [BW-1:0]    r_burst;
    logic             r_last;      // 0 = CPU held the last tenure, 1 = AUX
    logic [CNT_W-1:0] r_cpu_cnt;
    logic [CNT_W-1:0] r_aux_cnt;

    logic             w_burst_open;
    logic             w_cpu_gnt;
    logic             w_aux_gnt;

    // Burst limit only matters when the other master is actually waiting.
    assign w_burst_open = (r_burst < BMAX);

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_aux_gnt = 1'b0;
        unique case (r_owner)
            OWN_CPU: begin
                if (CpuReq && (w_burst_open || !AuxReq)) w_cpu_gnt = 1'b1;
                else if (AuxReq)                         w_aux_gnt = 1'b1;
            end
            OWN_AUX: begin
                if (AuxReq && (w_burst_open || !CpuReq)) w_aux_gnt = 1'b1;
                else if (CpuReq)                         w_cpu_gnt = 1'b1;
            end
            default: begin
                // From IDLE a tie goes to whichever master did not hold the last tenure.
                if (CpuReq && AuxReq) begin
                    w_cpu_gnt = r_last;
                    w_aux_gnt = !r_last;
                end else begin
                    w_cpu_gnt = CpuReq;
                    w_aux_gnt = AuxReq;
                end
            end
        endcase
        // Grants are forced off combinationally so a reset cuts an access mid-cycle.
        if (RST) begin
            w_cpu_gnt = 1'b0;
            w_aux_gnt = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_owner   <= OWN_IDLE;
            r_burst   <= '0;
            r_last    <= 1'b1;
            r_cpu_cnt <= '0;
            r_aux_cnt <= '0;
        end else if (w_cpu_gnt) begin
            r_cpu_cnt <= r_cpu_cnt + CNT_W'(1);
            if (r_owner == OWN_CPU) begin
                if (w_burst_open) r_burst <= r_burst + BW'(1);
            end else begin
                r_owner <= OWN_CPU;
                r_burst <= BW'(1);
                r_last  <= 1'b0;
            end
        end else if (w_aux_gnt) begin
            r_aux_cnt <= r_aux_cnt + CNT_W'(1);
            if (r_owner == OWN_AUX) begin
                if (w_burst_open) r_burst <= r_burst + BW'(1);
            end else begin
                r_owner <= OWN_AUX;
                r_burst <= BW'(1);
                r_last  <= 1'b1;
            end
        end else begin
            r_owner <= OWN_IDLE;
            r_burst <= '0;
        end
    end

    always_comb begin
        MemAddr  = '0;
        MemWData = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (w_cpu_gnt) begin
            MemAddr  = CpuAddr;
            MemWData = CpuWData;
            MemRead  = !CpuWrite;
            MemWrite = CpuWrite;
        end else if (w_aux_gnt) begin
            MemAddr  = AuxAddr;
            MemWData = AuxWData;
            MemRead  = !AuxWrite;
            MemWrite = AuxWrite;
        end
    end

    assign CpuGnt    = w_cpu_gnt;
    assign AuxGnt    = w_aux_gnt;
    assign CpuStall  = CpuReq & ~w_cpu_gnt;
    assign CpuRData  = MemRData;
    assign AuxRData  = MemRData;
    assign Owner     = r_owner;
    assign CpuAccCnt = r_cpu_cnt;
    assign AuxAccCnt = r_aux_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration/memory model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BMAX = 4;
    localparam int CW   = 4;

    logic          CLK, RST;
    logic          CpuReq, CpuWrite, AuxReq, AuxWrite;
    logic [AW-1:0] CpuAddr, AuxAddr, MemAddr;
    logic [DW-1:0] CpuWData, AuxWData, CpuRData, AuxRData, MemWData, MemRData;
    logic          CpuGnt, CpuStall, AuxGnt, MemRead, MemWrite;
    logic [1:0]    Owner;
    logic [CW-1:0] CpuAccCnt, AuxAccCnt;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(CpuGnt), .CpuStall(CpuStall), .CpuRData(CpuRData),
        .AuxReq(AuxReq), .AuxWrite(AuxWrite), .AuxAddr(AuxAddr), .AuxWData(AuxWData),
        .AuxGnt(AuxGnt), .AuxRData(AuxRData),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite), .MemWData(MemWData),
        .MemRData(MemRData),
        .Owner(Owner), .CpuAccCnt(CpuAccCnt), .AuxAccCnt(AuxAccCnt)
    );

    always #5 CLK = ~CLK;

    // Data memory seen by the DUT: combinational read, write on the clock edge.
    logic [DW-1:0] bmem [0:255];
    assign MemRData = bmem[MemAddr[9:2]];
    always @(posedge CLK) if (MemWrite) bmem[MemAddr[9:2]] <= MemWData;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // holder: whose tenure is running (0 none, 1 CPU, 2 AUX); run: grants in that tenure.
    int            m_holder, m_run, m_last, m_cc, m_ac;
    logic [DW-1:0] smem [0:255];

    function automatic int pick(input logic c, input logic a);
        if (!c && !a) return 0;
        if (c && !a)  return 1;
        if (a && !c)  return 2;
        if (m_holder == 0) return (m_last == 1) ? 2 : 1;
        if (m_run < BMAX)  return m_holder;
        return 3 - m_holder;
    endfunction

    always @(negedge CLK) begin
        int            g;
        logic          wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        if (RST) begin
            chk("rst_cpu_gnt", 32'(CpuGnt), 0);
            chk("rst_aux_gnt", 32'(AuxGnt), 0);
            chk("rst_mem_rd", 32'(MemRead), 0);
            chk("rst_mem_wr", 32'(MemWrite), 0);
            chk("rst_mem_addr", MemAddr, 0);
            chk("rst_mem_wdata", MemWData, 0);
            chk("rst_owner", 32'(Owner), 0);
            chk("rst_cpu_cnt", 32'(CpuAccCnt), 0);
            chk("rst_aux_cnt", 32'(AuxAccCnt), 0);
            m_holder = 0; m_run = 0; m_last = 2; m_cc = 0; m_ac = 0;
        end else begin
            g  = pick(CpuReq, AuxReq);
            wr = (g == 1) ? CpuWrite : (g == 2) ? AuxWrite : 1'b0;
            ea = (g == 1) ? CpuAddr  : (g == 2) ? AuxAddr  : '0;
            ew = (g == 1) ? CpuWData : (g == 2) ? AuxWData : '0;
            chk("m_cpu_gnt", 32'(CpuGnt), 32'(g == 1));
            chk("m_aux_gnt", 32'(AuxGnt), 32'(g == 2));
            chk("m_cpu_stall", 32'(CpuStall), 32'(CpuReq && g != 1));
            chk("m_mem_addr", MemAddr, ea);
            chk("m_mem_wdata", MemWData, ew);
            chk("m_mem_wr", 32'(MemWrite), 32'(g != 0 && wr));
            chk("m_mem_rd", 32'(MemRead), 32'(g != 0 && !wr));
            chk("m_owner", 32'(Owner), m_holder);
            chk("m_cpu_cnt", 32'(CpuAccCnt), m_cc % (1 << CW));
            chk("m_aux_cnt", 32'(AuxAccCnt), m_ac % (1 << CW));
            if (g == 1 && !wr) chk("m_cpu_rdata", CpuRData, smem[ea[9:2]]);
            if (g == 2 && !wr) chk("m_aux_rdata", AuxRData, smem[ea[9:2]]);
            if (g != 0 && wr) smem[ea[9:2]] = ew;
            if (g == 1) m_cc++;
            if (g == 2) m_ac++;
            if (g == 0) begin
                m_holder = 0; m_run = 0;
            end else if (g == m_holder) begin
                m_run = (m_run < BMAX) ? m_run + 1 : BMAX;
            end else begin
                m_holder = g; m_run = 1; m_last = g;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1; CpuReq = 0; AuxReq = 0;
        cyc();
        cyc();
        RST = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = '0;
            smem[i] = '0;
        end
        CLK = 0; RST = 1;
        CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h10; CpuWData = '0;
        AuxReq = 1; AuxWrite = 1; AuxAddr = 32'h40; AuxWData = 32'h1234;
        m_holder = 0; m_run = 0; m_last = 2; m_cc = 0; m_ac = 0;

        // Reset held with both masters requesting.
        cyc();
        chk("reset_cpu_gnt", 32'(CpuGnt), 0);
        chk("reset_aux_gnt", 32'(AuxGnt), 0);
        chk("reset_mem_wr", 32'(MemWrite), 0);
        chk("reset_owner", 32'(Owner), 0);
        cyc();
        RST = 0; CpuReq = 0; AuxReq = 0;

        // CPU alone: 4 writes then 4 readbacks.
        for (int i = 0; i < 8; i++) begin
            CpuReq   = 1;
            CpuWrite = (i < 4);
            CpuAddr  = 32'h10 + 32'(4 * (i % 4));
            CpuWData = 32'hA000_0000 + 32'(i);
            #1;
            chk("cpu_only_gnt", 32'(CpuGnt), 1);
            chk("cpu_only_stall", 32'(CpuStall), 0);
            if (i >= 4) chk("cpu_readback", CpuRData, 32'hA000_0000 + 32'(i - 4));
            cyc();
        end
        CpuReq = 0;
        chk("cpu_cnt_8", 32'(CpuAccCnt), 8);

        // Both requesting from IDLE: CPU x4, AUX x4, CPU x4.
        do_reset();
        CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h10;
        AuxReq = 1; AuxWrite = 0; AuxAddr = 32'h14;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("burst_cpu_gnt", 32'(CpuGnt), 32'(i < 4 || i >= 8));
            chk("burst_aux_gnt", 32'(AuxGnt), 32'(i >= 4 && i < 8));
            chk("burst_stall", 32'(CpuStall), 32'(i >= 4 && i < 8));
            cyc();
        end

        // AUX writes 0xDEADBEEF to 0x40, CPU reads it back.
        CpuReq = 0;
        AuxReq = 1; AuxWrite = 1; AuxAddr = 32'h40; AuxWData = 32'hDEAD_BEEF;
        #1;
        chk("aux_wr_gnt", 32'(AuxGnt), 1);
        cyc();
        AuxReq = 0;
        CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h40;
        #1;
        chk("cpu_rd_gnt", 32'(CpuGnt), 1);
        chk("cpu_rd_deadbeef", CpuRData, 32'hDEAD_BEEF);
        cyc();

        // CPU holds two grants, drops Req while AUX requests: same-cycle switch.
        do_reset();
        CpuReq = 1; CpuWrite = 0; CpuAddr = 32'h10;
        cyc();
        cyc();
        CpuReq = 0; AuxReq = 1; AuxWrite = 0; AuxAddr = 32'h40;
        #1;
        chk("drop_aux_gnt", 32'(AuxGnt), 1);
        chk("drop_cpu_gnt", 32'(CpuGnt), 0);
        cyc();
        chk("drop_owner_aux", 32'(Owner), 2);
        AuxReq = 0;
        cyc();

        // Reset in the middle of an AUX burst, then a tie goes to the CPU.
        do_reset();
        CpuReq = 1; AuxReq = 1; CpuWrite = 0; AuxWrite = 0;
        repeat (6) cyc();
        RST = 1;
        #1;
        chk("midrst_cpu_gnt", 32'(CpuGnt), 0);
        chk("midrst_aux_gnt", 32'(AuxGnt), 0);
        chk("midrst_mem_rd", 32'(MemRead), 0);
        cyc();
        RST = 0;
        #1;
        chk("post_rst_cpu_wins", 32'(CpuGnt), 1);
        chk("post_rst_aux_waits", 32'(AuxGnt), 0);
        cyc();

        // 17 AUX grants wrap a 4-bit counter to 1.
        do_reset();
        CpuReq = 0; AuxReq = 1; AuxWrite = 0; AuxAddr = 32'h40;
        repeat (17) cyc();
        chk("aux_cnt_wrap", 32'(AuxAccCnt), 1);
        AuxReq = 0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter for the single data-memory port of the RISCV core.
- Master 0 is the CPU data port. Master 1 (AUX) is a loader/debug/DMA agent that preloads or inspects data memory, e.g. the stack area or results such as Fac(N).
- Round-robin arbitration with a bounded burst tenure. Grants are same-cycle, so the CPU stalls only while AUX owns the port.
- Sits between u_RISCV and the data memory, which has a combinational read and writes on the CLK edge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BURST_MAX, 4, maximum consecutive grants to one master while the other master is requesting (>=1).
- CNT_W, 16, width of the per-master access counters.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- CpuReq  in  1  CPU access request.
- CpuWrite  in  1  1=write, 0=read.
- CpuAddr  in  ADDR_W  CPU address.
- CpuWData  in  DATA_W  CPU write data.
- CpuGnt  out  1  CPU access performed this cycle.
- CpuStall  out  1  CpuReq & ~CpuGnt.
- CpuRData  out  DATA_W  read data, valid when CpuGnt & ~CpuWrite.
- AuxReq, AuxWrite, AuxAddr, AuxWData  in  1/1/ADDR_W/DATA_W  AUX request fields, same meaning as the CPU fields.
- AuxGnt  out  1  AUX access performed this cycle.
- AuxRData  out  DATA_W  read data, valid when AuxGnt & ~AuxWrite.
- MemAddr  out  ADDR_W  memory address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemWData  out  DATA_W  memory write data.
- MemRData  in  DATA_W  memory read data (combinational).
- Owner  out  2  state: 0=IDLE, 1=CPU, 2=AUX.
- CpuAccCnt, AuxAccCnt  out  CNT_W  granted-access counters.

Behaviour:
- Registered state: Owner {IDLE, CPU, AUX}, burst_cnt (0..BURST_MAX), last (last tenure holder), both counters.
- Reset (async): Owner=IDLE, burst_cnt=0, last=AUX (so CPU wins the first tie), counters=0.
- While RST is high, CpuGnt=AuxGnt=0, MemRead=MemWrite=0 and MemAddr=MemWData=0, regardless of requests.
- Grant decision is combinational from the current Req inputs and registered state; at most one Gnt per cycle.
  - Owner=X and XReq and (burst_cnt<BURST_MAX or ~YReq): grant X; next burst_cnt=min(burst_cnt+1, BURST_MAX).
  - Owner=X, otherwise, with YReq: grant Y; next Owner=Y, burst_cnt=1, last=Y. This covers the owner dropping Req (switch in the same cycle) and burst expiry.
  - Owner=X and neither requesting: no grant; next Owner=IDLE, burst_cnt=0.
  - IDLE, single requester: grant it; Owner=it, burst_cnt=1, last=it.
  - IDLE, both requesting: grant the master that is not `last`.
- Memory mux follows the grant:
  - MemAddr and MemWData come from the granted master.
  - MemWrite = grant & Write; MemRead = grant & ~Write.
  - With no grant, all mux outputs are 0.
- Access timing:
  - Writes commit on the CLK edge that ends the grant cycle.
  - Read data is valid combinationally in the grant cycle.
  - Zero added latency.
- CpuRData and AuxRData are both driven from MemRData; data is valid only when the respective Gnt is high.
- Counters increment on every granted cycle of their master and wrap modulo 2^CNT_W.
- A master must hold Req, Write, Addr and WData stable until Gnt. Each Gnt cycle is exactly one access.
- Reset mid-burst: grants drop immediately. After RST falls, arbitration restarts from IDLE with the CPU favoured.

Test Plan:
- RST=1 with both Req high → CpuGnt=AuxGnt=0, MemWrite=MemRead=0, Owner=0, counters 0.
- CPU only: writes to 0x10..0x1C over 4 cycles, then reads them back → CpuGnt every cycle, CpuStall never asserted, CpuAccCnt=8, readback data matches.
- BURST_MAX=4, both Req held from IDLE after reset → CPU granted cycles 1–4 and AUX cycles 5–8, alternating thereafter. CpuStall is high exactly in AUX cycles.
- AUX writes 0xDEADBEEF to 0x40, then CPU reads 0x40 → CpuRData=0xDEADBEEF in the CPU grant cycle.
- CPU owns with burst_cnt=2 and drops Req while AuxReq=1 → AuxGnt in the same cycle, Owner=2 on the next edge.
- CNT_W=4, 17 AUX grants → AuxAccCnt=1. Separately, RST pulsed mid-burst → immediate Gnt=0, and the next tie is won by the CPU.
